l2_arbiter_rr: RTL and testbench
================================

# l2_arbiter_rr

Parametrised N-requester arbiter between the L1 caches (and any other line-granular masters) and the shared L2/physical-memory port. Grants one requester at a time, holds the grant for the whole transaction until the downstream `mem_resp`, and selects the next winner by round-robin or fixed priority. It is the generalised successor of the two-port icache/dcache arbiter and sits directly in front of the L2 cache.

## Interface
Parameters:
- NUM_PORTS, 2: number of requesters, ≥2; port 0 is the icache by convention.
- ADDR_WIDTH, 16: address width in bits.
- LINE_WIDTH, 128: cache-line width in bits.
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority with the lowest index winning.
- ID_WIDTH: derived as $clog2(NUM_PORTS); not overridable.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_address  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_read  in  NUM_PORTS  per-port read request.
- req_write  in  NUM_PORTS  per-port write request.
- req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line.
- req_rdata  out  NUM_PORTS*LINE_WIDTH  per-port read line.
- req_resp  out  NUM_PORTS  per-port response pulse.
- mem_address  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  LINE_WIDTH  downstream write line.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_rdata  in  LINE_WIDTH  downstream read line.
- mem_resp  in  1  downstream completion.
- grant_valid  out  1  high while in BUSY.
- grant_id  out  ID_WIDTH  registered index of the current or last grantee.

## Operation
- Port i is requesting when `req_read[i] | req_write[i]`.
- State machine has two states: IDLE and BUSY.
  - IDLE → BUSY when any port is requesting. The winner is latched into `grant_id`.
  - BUSY → IDLE on `mem_resp`.
  - Otherwise the state holds.
- Winner selection:
  - RR_MODE=1: search starts at `rr_ptr` and proceeds upward, wrapping modulo NUM_PORTS. On a grant to port g, `rr_ptr` ← (g+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
  - RR_MODE=0: lowest requesting index wins. `rr_ptr` is unused.
- In BUSY, port g = `grant_id` is forwarded combinationally:
  - `mem_address`, `mem_wdata`, `mem_read`, `mem_write` carry port g's live inputs.
  - `req_resp[g]` = `mem_resp`; `req_rdata` slice g = `mem_rdata`.
  - All other `req_resp` bits are 0 and all other `req_rdata` slices are 0.
- In IDLE:
  - `mem_read` = `mem_write` = 0; `mem_address` = 0; `mem_wdata` = 0.
  - All `req_resp` = 0 and all `req_rdata` = 0.
  - A `mem_resp` arriving in IDLE is ignored.
- Requester contract: hold the request and its address/data stable until `req_resp`, then drop the request in the following cycle. The arbiter does not check this contract. If the grantee drops its request mid-transaction, the arbiter stays BUSY, forwards the deasserted read/write, and waits for `mem_resp`.
- Non-granted requesters wait indefinitely. With RR_MODE=1, a continuously requesting port is granted within NUM_PORTS transactions.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system) clears the following immediately, without waiting for a clock edge:
  - state = IDLE, `grant_id` = 0, `rr_ptr` = 0.
  - Every output is 0: `grant_valid`, `mem_*`, `req_resp`, `req_rdata`.
- Reset during BUSY aborts the transaction and the downstream request drops at once.
- Grant latency: a request seen in IDLE at cycle 0 produces BUSY and the downstream request at cycle 1.
- Response path: `mem_resp` at cycle k gives `req_resp[g]` at cycle k with zero latency, and IDLE at cycle k+1.
- Turnaround: the earliest next downstream request is at cycle k+2. The mandatory IDLE bubble keeps a just-served port, which drops its request at k+1, from being re-granted.
- Minimum transaction length is 1 BUSY cycle (`mem_resp` in the first BUSY cycle).
- Simultaneous requests in IDLE: exactly one is granted per the selection rule; the others are not registered.

## Test plan
1. Reset: with rst_n=0 mid-BUSY (port 1, `mem_read`=1) → same-cycle `mem_read`=0, `grant_valid`=0, `grant_id`=0. After release, port 0 requesting → granted at the next edge.
2. Single read, NUM_PORTS=3: port 2 reads 16'h1234; L2 returns 128'hDEAD…BEEF with `mem_resp` after 5 BUSY cycles. Required:
   - `mem_address`=16'h1234 from cycle 1.
   - `req_resp`=3'b100 for exactly one cycle, with slice 2 = the returned line and slices 0/1 = 0.
   - IDLE on the next cycle.
3. Round-robin fairness, RR_MODE=1, NUM_PORTS=3: all ports hold requests continuously (re-asserted after each response) → grant order 0,1,2,0,1,2, with one IDLE cycle between grants.
4. Fixed priority, RR_MODE=0: ports 0 and 1 both always requesting → port 0 is granted every transaction and port 1 never. When port 0 stops, port 1 is granted on the next IDLE.
5. Write path: port 1 writes line 128'hA5…A5 to 16'h0040 → `mem_write`=1, `mem_wdata`=128'hA5…A5, `mem_read`=0 until `mem_resp`. Only `req_resp[1]` pulses.
6. Spurious `mem_resp` in IDLE with no requests → all `req_resp`=0 and the state stays IDLE. A 1-cycle transaction (`mem_resp` in the first BUSY cycle) → grant, response, IDLE, next grant at cycles 1, 1, 2, 3.

Source files
------------

// File: rtl/l2_arbiter_rr.sv
// l2_arbiter_rr: N-requester arbiter in front of the shared L2 / memory port.
// One grantee at a time, held until mem_resp; next winner by round-robin or fixed priority.
module l2_arbiter_rr #(
   parameter int unsigned  NUM_PORTS  = 2,
   parameter int unsigned  ADDR_WIDTH = 16,
   parameter int unsigned  LINE_WIDTH = 128,
   parameter int unsigned  RR_MODE    = 1,
   localparam int unsigned ID_WIDTH   = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
   input  logic [NUM_PORTS-1:0]            req_read,
   input  logic [NUM_PORTS-1:0]            req_write,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
   output logic [NUM_PORTS*LINE_WIDTH-1:0] req_rdata,
   output logic [NUM_PORTS-1:0]            req_resp,
   output logic [ADDR_WIDTH-1:0]           mem_address,
   output logic [LINE_WIDTH-1:0]           mem_wdata,
   output logic                            mem_read,
   output logic                            mem_write,
   input  logic [LINE_WIDTH-1:0]           mem_rdata,
   input  logic                            mem_resp,
   output logic                            grant_valid,
   output logic [ID_WIDTH-1:0]             grant_id
);

   localparam int unsigned SUM_WIDTH = ID_WIDTH + 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
   logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;

   logic [NUM_PORTS-1:0]   requesting;
   logic [ID_WIDTH-1:0]    search_base;
   logic [2*NUM_PORTS-1:0] req_dbl;
   logic [NUM_PORTS-1:0]   req_rot;
   logic                   win_found;
   logic [ID_WIDTH-1:0]    win_off;
   logic [SUM_WIDTH-1:0]   win_sum;
   logic [ID_WIDTH-1:0]    win_id;

   assign requesting  = req_read | req_write;
   assign search_base = (RR_MODE != 0) ? rr_ptr_q : '0;

   // Rotate requests so the search base sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin : winner_sel
      req_dbl   = {requesting, requesting} >> search_base;
      req_rot   = req_dbl[NUM_PORTS-1:0];
      win_found = 1'b0;
      win_off   = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_found = 1'b1;
            win_off   = ID_WIDTH'(i);
         end
      end
      win_sum = SUM_WIDTH'(search_base) + SUM_WIDTH'(win_off);
      if (win_sum >= SUM_WIDTH'(NUM_PORTS)) begin
         win_sum = win_sum - SUM_WIDTH'(NUM_PORTS);
      end
      win_id = win_sum[ID_WIDTH-1:0];
   end

   // Next-state: grant is latched only on the IDLE->BUSY edge.
   always_comb begin : next_state
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d    = BUSY;
               grant_id_d = win_id;
               rr_ptr_d   = (win_id == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : win_id + ID_WIDTH'(1);
            end
         end
         BUSY: begin
            if (mem_resp) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   // Grantee's live request is steered downstream; the response is steered back to it only.
   always_comb begin : forward
      mem_address = '0;
      mem_wdata   = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      req_resp    = '0;
      req_rdata   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if ((state_q == BUSY) && (grant_id_q == ID_WIDTH'(i))) begin
            mem_address = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata   = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
            mem_read    = req_read[i];
            mem_write   = req_write[i];
            req_resp[i] = mem_resp;
            req_rdata[i*LINE_WIDTH +: LINE_WIDTH] = mem_rdata;
         end
      end
   end

   assign grant_valid = (state_q == BUSY);
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_l2_arbiter_rr.sv
// Bench for l2_arbiter_rr: a round-robin instance and a fixed-priority instance, 3 ports each,
// directed scenarios plus a randomized run against a cycle-level behavioural model.
module tb_l2_arbiter_rr;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int LW = 128;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // round-robin instance
   logic [AW-1:0]   p_addr  [N];
   logic [LW-1:0]   p_wdata [N];
   logic [LW-1:0]   a_rdata [N];
   logic [N*AW-1:0] req_address;
   logic [N-1:0]    req_read, req_write, req_resp;
   logic [N*LW-1:0] req_wdata, req_rdata;
   logic [AW-1:0]   mem_address;
   logic [LW-1:0]   mem_wdata, mem_rdata;
   logic            mem_read, mem_write, mem_resp, grant_valid;
   logic [IW-1:0]   grant_id;

   // fixed-priority instance
   logic [N*AW-1:0] f_req_address;
   logic [N-1:0]    f_req_read, f_req_write, f_req_resp;
   logic [N*LW-1:0] f_req_wdata, f_req_rdata;
   logic [AW-1:0]   f_mem_address;
   logic [LW-1:0]   f_mem_wdata, f_mem_rdata;
   logic            f_mem_read, f_mem_write, f_mem_resp, f_grant_valid;
   logic [IW-1:0]   f_grant_id;

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign req_address[i*AW +: AW] = p_addr[i];
      assign req_wdata[i*LW +: LW]   = p_wdata[i];
      assign a_rdata[i]              = req_rdata[i*LW +: LW];
   end

   l2_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .req_address(req_address), .req_read(req_read), .req_write(req_write),
      .req_wdata(req_wdata), .req_rdata(req_rdata), .req_resp(req_resp),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .grant_valid(grant_valid), .grant_id(grant_id)
   );

   l2_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .req_address(f_req_address), .req_read(f_req_read), .req_write(f_req_write),
      .req_wdata(f_req_wdata), .req_rdata(f_req_rdata), .req_resp(f_req_resp),
      .mem_address(f_mem_address), .mem_wdata(f_mem_wdata), .mem_read(f_mem_read),
      .mem_write(f_mem_write), .mem_rdata(f_mem_rdata), .mem_resp(f_mem_resp),
      .grant_valid(f_grant_valid), .grant_id(f_grant_id)
   );

   int checks   = 0;
   int failures = 0;
   int m_ptr    = 0;   // model: first port searched on the next round-robin grant
   int m_gid    = 0;   // model: last grantee

   // first requesting port at or after ptr, wrapping; -1 if none
   function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
      for (int o = 0; o < N; o++) begin
         if (r[(ptr + o) % N]) return (ptr + o) % N;
      end
      return -1;
   endfunction

   function automatic int fp_pick(input logic [N-1:0] r);
      for (int i = 0; i < N; i++) begin
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic clear_a();
      req_read  = '0;
      req_write = '0;
      for (int i = 0; i < N; i++) begin
         p_addr[i]  = '0;
         p_wdata[i] = '0;
      end
      mem_rdata = '0;
      mem_resp  = 1'b0;
   endtask

   task automatic clear_b();
      f_req_address = '0;
      f_req_read    = '0;
      f_req_write   = '0;
      f_req_wdata   = '0;
      f_mem_rdata   = '0;
      f_mem_resp    = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_a();
      clear_b();
      mem_resp  = 1'b1;
      mem_rdata = {LW{1'b1}};
      #1;
      checks++;
      if (grant_valid !== 1'b0 || grant_id !== '0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
          mem_address !== '0 || mem_wdata !== '0 || req_resp !== '0 || req_rdata !== '0) begin
         failures++;
         $display("FAIL reset_state: gv=%b gid=%0d rd=%b wr=%b addr=%h resp=%b rdata_nz=%b, required all zero",
                  grant_valid, grant_id, mem_read, mem_write, mem_address, req_resp, |req_rdata);
      end
      checks++;
      if (f_grant_valid !== 1'b0 || f_grant_id !== '0) begin
         failures++;
         $display("FAIL reset_state_fp: gv=%b gid=%0d, required 0 0", f_grant_valid, f_grant_id);
      end
      mem_resp  = 1'b0;
      mem_rdata = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      m_gid = 0;
      // port 1 read, then reset mid-BUSY
      @(negedge clk);
      req_read[1] = 1'b1;
      p_addr[1]   = 16'h0100;
      @(negedge clk); #1;
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd1 || mem_read !== 1'b1) begin
         failures++;
         $display("FAIL reset_pre_busy: gv=%b gid=%0d rd=%b, required 1 1 1", grant_valid, grant_id, mem_read);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_read !== 1'b0 || grant_valid !== 1'b0 || grant_id !== '0 || mem_address !== '0) begin
         failures++;
         $display("FAIL reset_abort: rd=%b gv=%b gid=%0d addr=%h, required 0 0 0 0",
                  mem_read, grant_valid, grant_id, mem_address);
      end
      m_ptr = 0;
      m_gid = 0;
      clear_a();
      @(negedge clk);
      rst_n       = 1'b1;
      req_read[0] = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
         failures++;
         $display("FAIL reset_regrant: gv=%b gid=%0d, required 1 0", grant_valid, grant_id);
      end
      m_gid    = 0;
      m_ptr    = 1;
      mem_resp = 1'b1;
      #1;
      checks++;
      if (req_resp !== 3'b001) begin
         failures++;
         $display("FAIL reset_regrant_resp: resp=%b, required 001", req_resp);
      end
      @(negedge clk);
      clear_a();
      #1;
      checks++;
      if (grant_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_regrant_idle: gv=%b, required 0", grant_valid);
      end
   endtask

   task automatic test_single_read();
      logic [LW-1:0] line;
      line = {16'hDEAD, 96'h0, 16'hBEEF};
      @(negedge clk);
      req_read[2] = 1'b1;
      p_addr[2]   = 16'h1234;
      #1;
      checks++;
      if (grant_valid !== 1'b0 || mem_address !== '0 || mem_read !== 1'b0) begin
         failures++;
         $display("FAIL read_cycle0: gv=%b addr=%h rd=%b, required 0 0000 0", grant_valid, mem_address, mem_read);
      end
      for (int j = 0; j < 5; j++) begin
         @(negedge clk); #1;
         checks++;
         if (grant_valid !== 1'b1 || grant_id !== 2'd2 || mem_address !== 16'h1234 ||
             mem_read !== 1'b1 || mem_write !== 1'b0 || req_resp !== '0) begin
            failures++;
            $display("FAIL read_busy[%0d]: gv=%b gid=%0d addr=%h rd=%b wr=%b resp=%b, required 1 2 1234 1 0 000",
                     j, grant_valid, grant_id, mem_address, mem_read, mem_write, req_resp);
         end
      end
      m_gid = 2;
      m_ptr = 0;
      @(negedge clk);
      mem_rdata = line;
      mem_resp  = 1'b1;
      #1;
      checks++;
      if (req_resp !== 3'b100 || a_rdata[2] !== line || a_rdata[0] !== '0 || a_rdata[1] !== '0) begin
         failures++;
         $display("FAIL read_resp: resp=%b s2=%h s0_nz=%b s1_nz=%b, required 100 %h 0 0",
                  req_resp, a_rdata[2], |a_rdata[0], |a_rdata[1], line);
      end
      @(negedge clk);
      mem_resp    = 1'b0;
      req_read[2] = 1'b0;
      #1;
      checks++;
      if (grant_valid !== 1'b0 || req_resp !== '0 || req_rdata !== '0) begin
         failures++;
         $display("FAIL read_idle_after: gv=%b resp=%b rdata_nz=%b, required 0 000 0",
                  grant_valid, req_resp, |req_rdata);
      end
      clear_a();
   endtask

   task automatic test_rr_fairness();
      logic [N-1:0] served_mask;
      logic [N-1:0] exp_resp;
      int g;
      int lat;
      served_mask = '0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         mem_resp = 1'b0;
         req_read = ~served_mask;
         for (int i = 0; i < N; i++) p_addr[i] = AW'($urandom());
         #1;
         checks++;
         if (grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_bubble[%0d]: gv=%b, required 0", t, grant_valid);
         end
         g = rr_pick(req_read, m_ptr);
         @(negedge clk);
         req_read = '1;
         #1;
         checks++;
         if (grant_valid !== 1'b1 || grant_id !== IW'(g) || mem_address !== p_addr[g]) begin
            failures++;
            $display("FAIL rr_grant[%0d]: gv=%b gid=%0d addr=%h, required 1 %0d %h",
                     t, grant_valid, grant_id, mem_address, g, p_addr[g]);
         end
         checks++;
         if (grant_id !== IW'(t % 3)) begin
            failures++;
            $display("FAIL rr_order[%0d]: gid=%0d, required %0d", t, grant_id, t % 3);
         end
         m_gid = g;
         m_ptr = (g + 1) % N;
         lat   = $urandom_range(0, 3);
         for (int j = 0; j < lat; j++) begin
            @(negedge clk); #1;
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== IW'(g)) begin
               failures++;
               $display("FAIL rr_hold[%0d]: gv=%b gid=%0d, required 1 %0d", t, grant_valid, grant_id, g);
            end
         end
         mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
         mem_resp  = 1'b1;
         #1;
         exp_resp = N'(1) << g;
         checks++;
         if (req_resp !== exp_resp || a_rdata[g] !== mem_rdata) begin
            failures++;
            $display("FAIL rr_resp[%0d]: resp=%b, required %b", t, req_resp, exp_resp);
         end
         served_mask = exp_resp;
      end
      @(negedge clk);
      clear_a();
   endtask

   task automatic test_fixed_priority();
      int g;
      @(negedge clk);
      f_req_read = 3'b011;
      #1;
      checks++;
      if (f_grant_valid !== 1'b0) begin
         failures++;
         $display("FAIL fp_idle: gv=%b, required 0", f_grant_valid);
      end
      for (int t = 0; t < 5; t++) begin
         if (t == 4) f_req_read = 3'b010;
         g = fp_pick(f_req_read);
         @(negedge clk); #1;
         checks++;
         if (f_grant_valid !== 1'b1 || f_grant_id !== IW'(g)) begin
            failures++;
            $display("FAIL fp_grant[%0d]: gv=%b gid=%0d, required 1 %0d", t, f_grant_valid, f_grant_id, g);
         end
         f_mem_resp = 1'b1;
         #1;
         checks++;
         if (f_req_resp !== (N'(1) << g)) begin
            failures++;
            $display("FAIL fp_resp[%0d]: resp=%b, required %b", t, f_req_resp, N'(1) << g);
         end
         @(negedge clk);
         f_mem_resp = 1'b0;
         #1;
         checks++;
         if (f_grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL fp_bubble[%0d]: gv=%b, required 0", t, f_grant_valid);
         end
      end
      clear_b();
   endtask

   task automatic test_write();
      logic [LW-1:0] line;
      line = {16{8'hA5}};
      @(negedge clk);
      req_write[1] = 1'b1;
      p_addr[1]    = 16'h0040;
      p_wdata[1]   = line;
      p_wdata[0]   = {LW{1'b1}};
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); #1;
         checks++;
         if (grant_id !== 2'd1 || mem_write !== 1'b1 || mem_read !== 1'b0 ||
             mem_wdata !== line || mem_address !== 16'h0040 || req_resp !== '0) begin
            failures++;
            $display("FAIL write_busy[%0d]: gid=%0d wr=%b rd=%b wdata=%h addr=%h resp=%b, required 1 1 0 %h 0040 000",
                     j, grant_id, mem_write, mem_read, mem_wdata, mem_address, req_resp, line);
         end
      end
      m_gid    = 1;
      m_ptr    = 2;
      mem_resp = 1'b1;
      #1;
      checks++;
      if (req_resp !== 3'b010) begin
         failures++;
         $display("FAIL write_resp: resp=%b, required 010", req_resp);
      end
      @(negedge clk);
      clear_a();
      #1;
      checks++;
      if (mem_write !== 1'b0 || mem_wdata !== '0 || grant_valid !== 1'b0) begin
         failures++;
         $display("FAIL write_idle: wr=%b wdata_nz=%b gv=%b, required 0 0 0", mem_write, |mem_wdata, grant_valid);
      end
   endtask

   task automatic test_spurious_short();
      int g1;
      int g2;
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      checks++;
      if (req_resp !== '0 || grant_valid !== 1'b0) begin
         failures++;
         $display("FAIL spurious_resp: resp=%b gv=%b, required 000 0", req_resp, grant_valid);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      checks++;
      if (grant_valid !== 1'b0) begin
         failures++;
         $display("FAIL spurious_stay_idle: gv=%b, required 0", grant_valid);
      end
      // 1-cycle transaction: grant/resp at cycle 1, IDLE at 2, next grant at 3
      @(negedge clk);
      req_read = 3'b101;
      g1 = rr_pick(req_read, m_ptr);
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== IW'(g1) || req_resp !== (N'(1) << g1)) begin
         failures++;
         $display("FAIL short_c1: gv=%b gid=%0d resp=%b, required 1 %0d %b",
                  grant_valid, grant_id, req_resp, g1, N'(1) << g1);
      end
      m_gid = g1;
      m_ptr = (g1 + 1) % N;
      @(negedge clk);
      mem_resp = 1'b0;
      req_read = req_read & ~(N'(1) << g1);
      #1;
      checks++;
      if (grant_valid !== 1'b0) begin
         failures++;
         $display("FAIL short_c2: gv=%b, required 0", grant_valid);
      end
      g2 = rr_pick(req_read, m_ptr);
      @(negedge clk); #1;
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== IW'(g2)) begin
         failures++;
         $display("FAIL short_c3: gv=%b gid=%0d, required 1 %0d", grant_valid, grant_id, g2);
      end
      m_gid    = g2;
      m_ptr    = (g2 + 1) % N;
      mem_resp = 1'b1;
      @(negedge clk);
      clear_a();
   endtask

   task automatic test_random();
      logic [N-1:0]  pend;
      logic [N-1:0]  drop;
      logic [N-1:0]  exp_resp;
      logic [AW-1:0] exp_addr;
      logic [LW-1:0] exp_wd;
      logic [LW-1:0] exp_line;
      logic          exp_rd, exp_wr, m_busy, bad;
      int            g;
      pend   = '0;
      drop   = '0;
      m_busy = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (drop[i]) begin
               req_read[i]  = 1'b0;
               req_write[i] = 1'b0;
               pend[i]      = 1'b0;
            end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i]      = 1'b1;
               req_read[i]  = ($urandom_range(0, 1) == 1);
               req_write[i] = !req_read[i];
               p_addr[i]    = AW'($urandom());
               p_wdata[i]   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
         end
         drop      = '0;
         mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
         mem_resp  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         #1;
         exp_resp = '0;
         exp_addr = '0;
         exp_wd   = '0;
         exp_rd   = 1'b0;
         exp_wr   = 1'b0;
         if (m_busy) begin
            exp_addr        = p_addr[m_gid];
            exp_wd          = p_wdata[m_gid];
            exp_rd          = req_read[m_gid];
            exp_wr          = req_write[m_gid];
            exp_resp[m_gid] = mem_resp;
         end
         checks++;
         if (grant_valid !== m_busy || grant_id !== IW'(m_gid)) begin
            failures++;
            $display("FAIL rand_grant[%0d]: gv=%b gid=%0d, required %b %0d", c, grant_valid, grant_id, m_busy, m_gid);
         end
         checks++;
         if (mem_address !== exp_addr || mem_read !== exp_rd || mem_write !== exp_wr || mem_wdata !== exp_wd) begin
            failures++;
            $display("FAIL rand_fwd[%0d]: addr=%h rd=%b wr=%b, required %h %b %b",
                     c, mem_address, mem_read, mem_write, exp_addr, exp_rd, exp_wr);
         end
         checks++;
         if (req_resp !== exp_resp) begin
            failures++;
            $display("FAIL rand_resp[%0d]: resp=%b, required %b", c, req_resp, exp_resp);
         end
         bad = 1'b0;
         for (int i = 0; i < N; i++) begin
            exp_line = (m_busy && i == m_gid) ? mem_rdata : '0;
            if (a_rdata[i] !== exp_line) bad = 1'b1;
         end
         checks++;
         if (bad) begin
            failures++;
            $display("FAIL rand_rdata[%0d]: slices s0=%h s1=%h s2=%h, required only slice %0d = %h while busy=%b",
                     c, a_rdata[0], a_rdata[1], a_rdata[2], m_gid, mem_rdata, m_busy);
         end
         // advance the model across the coming clock edge
         if (!m_busy) begin
            g = rr_pick(req_read | req_write, m_ptr);
            if (g >= 0) begin
               m_busy = 1'b1;
               m_gid  = g;
               m_ptr  = (g + 1) % N;
            end
         end else if (mem_resp) begin
            m_busy      = 1'b0;
            drop[m_gid] = 1'b1;
         end
      end
   endtask

   initial begin
      clear_a();
      clear_b();
      test_reset();
      test_single_read();
      test_rr_fairness();
      test_fixed_priority();
      test_write();
      test_spurious_short();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
